// File: rtl/rib_uart.sv
// rib_uart: RIB slave UART with TX FIFO, 8N1 serialiser and single-byte RX buffer.
// Define UART_RX_EN to build the receive path (STATUS rx bits, RXDATA, irq_o).
//
// TX/RX FSM states
//   state   | meaning
//   S_IDLE  | line idle; TX waits for tx_en and FIFO data, RX waits for a falling edge
//   S_START | start bit; RX re-samples it at the half-bit point
//   S_DATA  | 8 data bits, LSB first, one per BAUD cycles
//   S_STOP  | stop bit; RX commits the byte or flags frame_err
module rib_uart #(
   parameter logic [15:0] DEFAULT_DIV   = 16'd434,
   parameter int          TX_FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   input  logic        we_i,
   output logic [31:0] data_o,
   output logic        tx_pin_o,
   input  logic        rx_pin_i,
   output logic        irq_o
);

   localparam int PW = $clog2(TX_FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   logic w_wr_ctrl, w_wr_status, w_wr_baud, w_wr_txdata;
   assign w_wr_ctrl   = we_i && (addr_i[7:0] == 8'h00);
   assign w_wr_status = we_i && (addr_i[7:0] == 8'h04);
   assign w_wr_baud   = we_i && (addr_i[7:0] == 8'h08);
   assign w_wr_txdata = we_i && (addr_i[7:0] == 8'h0C);

   logic        r_tx_en;
   logic [15:0] r_baud;
   logic [15:0] w_baud_wr;
   assign w_baud_wr = (data_i[15:0] < 16'd4) ? 16'd4 : data_i[15:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx_en <= 1'b0;
         r_baud  <= DEFAULT_DIV;
      end else begin
         if (w_wr_ctrl) r_tx_en <= data_i[0];
         if (w_wr_baud) r_baud  <= w_baud_wr;
      end
   end

   logic [7:0]    r_fifo [TX_FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [PW:0]   r_count;
   logic          w_full, w_empty, w_push, w_pop;

   assign w_full  = (r_count == (PW+1)'(TX_FIFO_DEPTH));
   assign w_empty = (r_count == '0);
   // A push is judged against the pre-pop fill level, so a full FIFO drops it.
   assign w_push  = w_wr_txdata && !w_full;

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= data_i[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   state_t      r_tx_state, w_tx_state_nxt;
   logic [15:0] r_tx_cnt;
   logic [2:0]  r_tx_bit;
   logic [7:0]  r_tx_data;
   logic        w_tx_term, w_tx_pin, w_tx_busy;

   assign w_tx_term = (r_tx_cnt >= r_baud - 16'd1);
   // Popping straight out of STOP gives back-to-back frames with no idle gap.
   assign w_pop     = r_tx_en && !w_empty &&
                      ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && w_tx_term));
   assign w_tx_busy = (r_tx_state != S_IDLE) || !w_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx_state <= S_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_data  <= '0;
      end else begin
         r_tx_state <= w_tx_state_nxt;
         r_tx_cnt   <= ((r_tx_state == S_IDLE) || w_tx_term) ? 16'd0 : r_tx_cnt + 16'd1;
         if (w_pop) begin
            r_tx_data <= r_fifo[r_rd_ptr];
            r_tx_bit  <= '0;
         end else if ((r_tx_state == S_DATA) && w_tx_term) begin
            r_tx_bit  <= r_tx_bit + 3'd1;
         end
      end
   end

   always_comb begin
      w_tx_state_nxt = r_tx_state;
      case (r_tx_state)
         S_IDLE:  if (w_pop) w_tx_state_nxt = S_START;
         S_START: if (w_tx_term) w_tx_state_nxt = S_DATA;
         S_DATA:  if (w_tx_term && (r_tx_bit == 3'd7)) w_tx_state_nxt = S_STOP;
         S_STOP:  if (w_tx_term) w_tx_state_nxt = w_pop ? S_START : S_IDLE;
         default: w_tx_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_tx_pin = 1'b1;
      case (r_tx_state)
         S_START: w_tx_pin = 1'b0;
         S_DATA:  w_tx_pin = r_tx_data[r_tx_bit];
         default: w_tx_pin = 1'b1;
      endcase
   end

   assign tx_pin_o = w_tx_pin;

   logic       w_rx_en_rd, w_valid_rd, w_overrun_rd, w_frame_err_rd;
   logic [7:0] w_rxdata_rd;

`ifdef UART_RX_EN
   logic        r_rx_en, r_rx_sync1, r_rx_sync2, r_rx_prev;
   state_t      r_rx_state, w_rx_state_nxt;
   logic [15:0] r_rx_cnt;
   logic [2:0]  r_rx_bit;
   logic [7:0]  r_rx_shift, r_rxdata;
   logic        r_rx_valid, r_rx_overrun, r_frame_err, r_irq;
   logic        w_rx_fall, w_rx_term, w_rx_half_term, w_rx_tick;
   logic        w_rx_done_ok, w_rx_done_err;
   logic        w_rx_en_nxt, w_rx_valid_nxt, w_rx_overrun_nxt, w_frame_err_nxt;

   assign w_rx_fall      = r_rx_prev && !r_rx_sync2;
   assign w_rx_term      = (r_rx_cnt >= r_baud - 16'd1);
   assign w_rx_half_term = (r_rx_cnt >= {1'b0, r_baud[15:1]} - 16'd1);
   assign w_rx_tick      = ((r_rx_state == S_START) && w_rx_half_term) ||
                           (((r_rx_state == S_DATA) || (r_rx_state == S_STOP)) && w_rx_term);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_sync1 <= 1'b1;
         r_rx_sync2 <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_en    <= 1'b0;
         r_rx_state <= S_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_sync1 <= rx_pin_i;
         r_rx_sync2 <= r_rx_sync1;
         r_rx_prev  <= r_rx_sync2;
         r_rx_en    <= w_rx_en_nxt;
         r_rx_state <= w_rx_state_nxt;
         r_rx_cnt   <= ((r_rx_state == S_IDLE) || w_rx_tick) ? 16'd0 : r_rx_cnt + 16'd1;
         if (r_rx_state == S_START) begin
            r_rx_bit <= '0;
         end else if ((r_rx_state == S_DATA) && w_rx_term) begin
            r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
         end
      end
   end

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      if (!r_rx_en) begin
         w_rx_state_nxt = S_IDLE;
      end else begin
         case (r_rx_state)
            S_IDLE:  if (w_rx_fall) w_rx_state_nxt = S_START;
            S_START: if (w_rx_half_term) w_rx_state_nxt = r_rx_sync2 ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_term && (r_rx_bit == 3'd7)) w_rx_state_nxt = S_STOP;
            S_STOP:  if (w_rx_term) w_rx_state_nxt = S_IDLE;
            default: w_rx_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_rx_done_ok  = 1'b0;
      w_rx_done_err = 1'b0;
      if (r_rx_en && (r_rx_state == S_STOP) && w_rx_term) begin
         w_rx_done_ok  = r_rx_sync2;
         w_rx_done_err = !r_rx_sync2;
      end
   end

   // Hardware set beats a same-cycle W1C clear.
   assign w_rx_en_nxt      = w_wr_ctrl ? data_i[1] : r_rx_en;
   assign w_rx_valid_nxt   = w_rx_done_ok ? 1'b1 :
                             (w_wr_status && data_i[1]) ? 1'b0 : r_rx_valid;
   assign w_rx_overrun_nxt = (w_rx_done_ok && r_rx_valid) ? 1'b1 :
                             (w_wr_status && data_i[2]) ? 1'b0 : r_rx_overrun;
   assign w_frame_err_nxt  = w_rx_done_err ? 1'b1 :
                             (w_wr_status && data_i[4]) ? 1'b0 : r_frame_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_valid   <= 1'b0;
         r_rx_overrun <= 1'b0;
         r_frame_err  <= 1'b0;
         r_rxdata     <= '0;
         r_irq        <= 1'b0;
      end else begin
         r_rx_valid   <= w_rx_valid_nxt;
         r_rx_overrun <= w_rx_overrun_nxt;
         r_frame_err  <= w_frame_err_nxt;
         r_irq        <= w_rx_valid_nxt && w_rx_en_nxt;
         if (w_rx_done_ok) r_rxdata <= r_rx_shift;
      end
   end

   assign w_rx_en_rd     = r_rx_en;
   assign w_valid_rd     = r_rx_valid;
   assign w_overrun_rd   = r_rx_overrun;
   assign w_frame_err_rd = r_frame_err;
   assign w_rxdata_rd    = r_rxdata;
   assign irq_o          = r_irq;

   logic w_unused;
   assign w_unused = &{1'b0, addr_i[31:8], data_i[31:16]};
`else
   assign w_rx_en_rd     = 1'b0;
   assign w_valid_rd     = 1'b0;
   assign w_overrun_rd   = 1'b0;
   assign w_frame_err_rd = 1'b0;
   assign w_rxdata_rd    = 8'd0;
   assign irq_o          = 1'b0;

   logic w_unused;
   assign w_unused = &{1'b0, addr_i[31:8], data_i[31:16], rx_pin_i};
`endif

   always_comb begin
      data_o = '0;
      case (addr_i[7:0])
         8'h00:   data_o = {30'd0, w_rx_en_rd, r_tx_en};
         8'h04:   data_o = {27'd0, w_frame_err_rd, w_full, w_overrun_rd, w_valid_rd, w_tx_busy};
         8'h08:   data_o = {16'd0, r_baud};
         8'h10:   data_o = {24'd0, w_rxdata_rd};
         default: data_o = '0;
      endcase
   end

endmodule
